// File: rtl/hazard_control_unit.sv
// Hazard controller: forwarding selects, stall/flush generation and
// a counter FSM that holds EX for multi-cycle mul/div operations.
module hazard_control_unit #(
   parameter int REG_ADDR_W  = 5,
   parameter int MDU_LATENCY = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] RsD,
   input  logic [REG_ADDR_W-1:0] RtD,
   input  logic [REG_ADDR_W-1:0] RsE,
   input  logic [REG_ADDR_W-1:0] RtE,
   input  logic [REG_ADDR_W-1:0] WriteRegE,
   input  logic [REG_ADDR_W-1:0] WriteRegM,
   input  logic [REG_ADDR_W-1:0] WriteRegW,
   input  logic                  RegWriteE,
   input  logic                  RegWriteM,
   input  logic                  RegWriteW,
   input  logic                  MemtoRegE,
   input  logic                  MemtoRegM,
   input  logic                  BranchD,
   input  logic                  PCSrcD,
   input  logic                  JumpD,
   input  logic                  MduStartE,
   output logic [1:0]            ForwardAE,
   output logic [1:0]            ForwardBE,
   output logic                  ForwardAD,
   output logic                  ForwardBD,
   output logic                  StallF,
   output logic                  StallD,
   output logic                  StallE,
   output logic                  FlushD,
   output logic                  FlushE,
   output logic                  FlushM,
   output logic                  MduBusy
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       mdustall;
   logic       lwstall, branchstall;
   logic       e_hit_d, m_hit_d;
   logic [1:0] fwd_a, fwd_b;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      mdustall  = 1'b0;
      unique case (state)
         IDLE: begin
            if (MduStartE) begin
               mdustall  = 1'b1;
               state_nxt = BUSY;
               cnt_nxt   = 4'(MDU_LATENCY - 1);
            end
         end
         BUSY: begin
            cnt_nxt  = cnt - 4'd1;
            mdustall = (cnt > 4'd1);
            if (cnt <= 4'd1) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // MEM result takes priority over WB; register 0 never forwards
   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (RsE != '0 && RegWriteM && WriteRegM == RsE)
         fwd_a = 2'b10;
      else if (RsE != '0 && RegWriteW && WriteRegW == RsE)
         fwd_a = 2'b01;
      if (RtE != '0 && RegWriteM && WriteRegM == RtE)
         fwd_b = 2'b10;
      else if (RtE != '0 && RegWriteW && WriteRegW == RtE)
         fwd_b = 2'b01;
   end

   always_comb begin
      lwstall = MemtoRegE && RtE != '0
                && (RtE == RsD || RtE == RtD);
      e_hit_d = RegWriteE && WriteRegE != '0
                && (WriteRegE == RsD || WriteRegE == RtD);
      m_hit_d = MemtoRegM && WriteRegM != '0
                && (WriteRegM == RsD || WriteRegM == RtD);
      branchstall = BranchD && (e_hit_d || m_hit_d);
   end

   always_comb begin
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
      ForwardAD = RsD != '0 && RegWriteM && WriteRegM == RsD;
      ForwardBD = RtD != '0 && RegWriteM && WriteRegM == RtD;
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      FlushE    = 1'b0;
      FlushM    = 1'b0;
      if (mdustall) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         FlushM = 1'b1;
      end else if (lwstall || branchstall) begin
         StallF = 1'b1;
         StallD = 1'b1;
         FlushE = 1'b1;
      end
      // redirect waits until decode is no longer held
      FlushD  = (PCSrcD || JumpD) && !StallD;
      MduBusy = (state == BUSY);
      if (reset) begin
         ForwardAE = 2'b00;
         ForwardBE = 2'b00;
         ForwardAD = 1'b0;
         ForwardBD = 1'b0;
         StallF    = 1'b0;
         StallD    = 1'b0;
         StallE    = 1'b0;
         FlushD    = 1'b1;
         FlushE    = 1'b1;
         FlushM    = 1'b1;
         MduBusy   = 1'b0;
      end
   end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed scenarios plus
// randomized traffic against a cycle-timestamp reference model.
module tb_hazard_control_unit;

   localparam int W   = 5;
   localparam int LAT = 4;

   logic clk = 1'b0;
   logic reset;
   logic [W-1:0] RsD, RtD, RsE, RtE;
   logic [W-1:0] WriteRegE, WriteRegM, WriteRegW;
   logic RegWriteE, RegWriteM, RegWriteW;
   logic MemtoRegE, MemtoRegM;
   logic BranchD, PCSrcD, JumpD, MduStartE;
   logic [1:0] ForwardAE, ForwardBE;
   logic ForwardAD, ForwardBD;
   logic StallF, StallD, StallE;
   logic FlushD, FlushE, FlushM, MduBusy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int mstart = -1;
   logic [12:0] obs, exp_v;

   always #5 clk = ~clk;

   hazard_control_unit #(.REG_ADDR_W(W), .MDU_LATENCY(LAT)) dut (
      .clk(clk), .reset(reset),
      .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
      .WriteRegE(WriteRegE), .WriteRegM(WriteRegM),
      .WriteRegW(WriteRegW),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
      .RegWriteW(RegWriteW),
      .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
      .BranchD(BranchD), .PCSrcD(PCSrcD), .JumpD(JumpD),
      .MduStartE(MduStartE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
      .StallF(StallF), .StallD(StallD), .StallE(StallE),
      .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
      .MduBusy(MduBusy)
   );

   assign obs = {ForwardAE, ForwardBE, ForwardAD, ForwardBD,
                 StallF, StallD, StallE,
                 FlushD, FlushE, FlushM, MduBusy};

   // Cycles elapsed since the mul/div op entered EX, -1 when none is active
   function automatic int mdu_phase();
      if (mstart >= 0 && cyc - mstart < LAT) return cyc - mstart;
      return -1;
   endfunction

   function automatic logic [1:0] fwd_sel(input logic [W-1:0] r);
      if (r != 0 && RegWriteM && WriteRegM == r) return 2'b10;
      if (r != 0 && RegWriteW && WriteRegW == r) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [12:0] expect_out();
      int ph;
      logic mstall, mbusy, lw, br, hold;
      logic sf, sd, se, fd, fe, fm;
      logic ad, bd;
      ph = mdu_phase();
      if (ph < 0 && MduStartE) ph = 0;
      mstall = ph >= 0 && ph <= LAT - 2;
      mbusy  = ph >= 1;
      lw = MemtoRegE && RtE != 0 && (RtE == RsD || RtE == RtD);
      br = BranchD &&
           ((RegWriteE && WriteRegE != 0 &&
             (WriteRegE == RsD || WriteRegE == RtD)) ||
            (MemtoRegM && WriteRegM != 0 &&
             (WriteRegM == RsD || WriteRegM == RtD)));
      hold = lw || br;
      sf = mstall || hold;
      sd = sf;
      se = mstall;
      fe = !mstall && hold;
      fm = mstall;
      fd = (PCSrcD || JumpD) && !sd;
      ad = RsD != 0 && RegWriteM && WriteRegM == RsD;
      bd = RtD != 0 && RegWriteM && WriteRegM == RtD;
      if (reset)
         return {2'b00, 2'b00, 1'b0, 1'b0, 3'b000,
                 1'b1, 1'b1, 1'b1, 1'b0};
      return {fwd_sel(RsE), fwd_sel(RtE), ad, bd, sf, sd, se,
              fd, fe, fm, mbusy};
   endfunction

   task automatic tick();
      @(posedge clk);
      if (reset) mstart = -1;
      else if (mdu_phase() < 0 && MduStartE) mstart = cyc;
      cyc++;
      #1;
   endtask

   task automatic clear_inputs();
      {RsD, RtD, RsE, RtE} = '0;
      {WriteRegE, WriteRegM, WriteRegW} = '0;
      {RegWriteE, RegWriteM, RegWriteW} = '0;
      {MemtoRegE, MemtoRegM} = '0;
      {BranchD, PCSrcD, JumpD, MduStartE} = '0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b1;
      tick();
      RsE = 5'd3; RegWriteM = 1'b1; WriteRegM = 5'd3;
      MduStartE = 1'b1; MemtoRegE = 1'b1; RtE = 5'd3; RsD = 5'd3;
      @(negedge clk);
      exp_v = expect_out();
      total++;
      if (obs !== exp_v || obs !== 13'b0000_00_000_111_0) begin
         bad++;
         $display("FAIL reset got=%b exp=%b", obs, exp_v);
      end
      tick();
      clear_inputs();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_forwarding();
      clear_inputs();
      RsE = 5'd5; RegWriteM = 1'b1; WriteRegM = 5'd5;
      RegWriteW = 1'b1; WriteRegW = 5'd5;
      @(negedge clk);
      exp_v = expect_out();
      total++;
      if (ForwardAE !== 2'b10 || obs !== exp_v) begin
         bad++;
         $display("FAIL fwd_mem got=%b exp=%b", obs, exp_v);
      end
      tick();
      RegWriteM = 1'b0;
      @(negedge clk);
      exp_v = expect_out();
      total++;
      if (ForwardAE !== 2'b01 || obs !== exp_v) begin
         bad++;
         $display("FAIL fwd_wb got=%b exp=%b", obs, exp_v);
      end
      tick();
      clear_inputs();
      RtE = 5'd0; RsD = 5'd0; RegWriteM = 1'b1; WriteRegM = 5'd0;
      RegWriteW = 1'b1;
      @(negedge clk);
      exp_v = expect_out();
      total++;
      if (ForwardBE !== 2'b00 || ForwardAD !== 1'b0
          || obs !== exp_v) begin
         bad++;
         $display("FAIL fwd_r0 got=%b exp=%b", obs, exp_v);
      end
      tick();
      RsD = 5'd7; RtD = 5'd7; WriteRegM = 5'd7;
      @(negedge clk);
      exp_v = expect_out();
      total++;
      if (ForwardAD !== 1'b1 || ForwardBD !== 1'b1
          || obs !== exp_v) begin
         bad++;
         $display("FAIL fwd_dec got=%b exp=%b", obs, exp_v);
      end
      tick();
   endtask

   task automatic test_lwstall();
      clear_inputs();
      MemtoRegE = 1'b1; RtE = 5'd8; RsD = 5'd8;
      @(negedge clk);
      exp_v = expect_out();
      total++;
      if ({StallF, StallD, FlushE, StallE} !== 4'b1110
          || obs !== exp_v) begin
         bad++;
         $display("FAIL lwstall got=%b exp=%b", obs, exp_v);
      end
      tick();
      MemtoRegE = 1'b0;
      @(negedge clk);
      exp_v = expect_out();
      total++;
      if ({StallF, StallD, FlushE} !== 3'b000 || obs !== exp_v) begin
         bad++;
         $display("FAIL lw_release got=%b exp=%b", obs, exp_v);
      end
      tick();
   endtask

   task automatic test_mdu();
      logic [4:0] stall_tab, busy_tab;
      stall_tab = 5'b00111;
      busy_tab  = 5'b01110;
      clear_inputs();
      for (int i = 0; i < 5; i++) begin
         MduStartE = (i < 4);
         @(negedge clk);
         exp_v = expect_out();
         total++;
         if (obs !== exp_v || StallE !== stall_tab[i]
             || FlushM !== stall_tab[i]
             || MduBusy !== busy_tab[i]) begin
            bad++;
            $display("FAIL mdu c%0d got=%b exp=%b", i, obs, exp_v);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid_busy();
      clear_inputs();
      MduStartE = 1'b1;
      for (int i = 0; i < 3; i++) begin
         reset = (i == 2);
         @(negedge clk);
         exp_v = expect_out();
         total++;
         if (obs !== exp_v) begin
            bad++;
            $display("FAIL mdu_rst c%0d got=%b exp=%b", i, obs, exp_v);
         end
         tick();
      end
      reset = 1'b0;
      MduStartE = 1'b0;
      @(negedge clk);
      exp_v = expect_out();
      total++;
      if (MduBusy !== 1'b0 || StallE !== 1'b0 || obs !== exp_v) begin
         bad++;
         $display("FAIL mdu_after_rst got=%b exp=%b", obs, exp_v);
      end
      tick();
      MduStartE = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         exp_v = expect_out();
         total++;
         if (obs !== exp_v || StallE !== (i < 3)) begin
            bad++;
            $display("FAIL mdu_restart c%0d got=%b exp=%b",
                     i, obs, exp_v);
         end
         tick();
      end
      MduStartE = 1'b0;
      tick();
   endtask

   task automatic test_branch();
      clear_inputs();
      BranchD = 1'b1; PCSrcD = 1'b1; RsD = 5'd9;
      RegWriteE = 1'b1; WriteRegE = 5'd9;
      @(negedge clk);
      exp_v = expect_out();
      total++;
      if (StallD !== 1'b1 || FlushD !== 1'b0 || obs !== exp_v) begin
         bad++;
         $display("FAIL br_stall got=%b exp=%b", obs, exp_v);
      end
      tick();
      WriteRegE = 5'd12;
      @(negedge clk);
      exp_v = expect_out();
      total++;
      if (StallD !== 1'b0 || FlushD !== 1'b1 || obs !== exp_v) begin
         bad++;
         $display("FAIL br_redirect got=%b exp=%b", obs, exp_v);
      end
      tick();
      clear_inputs();
      BranchD = 1'b1; JumpD = 1'b1; RtD = 5'd4;
      MemtoRegM = 1'b1; WriteRegM = 5'd4;
      @(negedge clk);
      exp_v = expect_out();
      total++;
      if (StallD !== 1'b1 || FlushD !== 1'b0 || obs !== exp_v) begin
         bad++;
         $display("FAIL br_load got=%b exp=%b", obs, exp_v);
      end
      tick();
   endtask

   task automatic test_random();
      clear_inputs();
      for (int i = 0; i < 600; i++) begin
         reset     = ($urandom_range(0, 39) == 0);
         RsD       = W'($urandom_range(0, 3));
         RtD       = W'($urandom_range(0, 3));
         RsE       = W'($urandom_range(0, 3));
         RtE       = W'($urandom_range(0, 3));
         WriteRegE = W'($urandom_range(0, 3));
         WriteRegM = W'($urandom_range(0, 3));
         WriteRegW = W'($urandom_range(0, 3));
         RegWriteE = 1'($urandom);
         RegWriteM = 1'($urandom);
         RegWriteW = 1'($urandom);
         MemtoRegE = ($urandom_range(0, 3) == 0);
         MemtoRegM = ($urandom_range(0, 3) == 0);
         BranchD   = 1'($urandom);
         PCSrcD    = 1'($urandom);
         JumpD     = ($urandom_range(0, 3) == 0);
         MduStartE = ($urandom_range(0, 3) == 0);
         @(negedge clk);
         exp_v = expect_out();
         total++;
         if (obs !== exp_v) begin
            bad++;
            $display("FAIL random i=%0d got=%b exp=%b", i, obs, exp_v);
         end
         tick();
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      test_reset();
      test_forwarding();
      test_lwstall();
      test_mdu();
      test_reset_mid_busy();
      test_branch();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
